rio_host_param: RTL and testbench

Parametrised host side of the remote-IO (RIO) single-wire link. It serialises read and write requests of configurable address and data width onto one open-drain-style bidirectional data line (`sdio`, pulled high on the board). It also generates the free-running target clock, adds even parity in both directions, and returns read data with a parity-error flag. It replaces the fixed 8-bit host and sits between a local request/response bus and a RIO target on the far end of the cable.

---
 rtl/rio_host_param.sv | 179 +++++++++++++++++
 tb/tb_rio_host_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rio_host_param.sv
// rtl/rio_host_param.sv - parametrised RIO single-wire link host (serialiser, target clock, parity)
module rio_host_param #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CLKDIV     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_perr,
    output logic                  clock_target,
    output logic                  sdio_o,
    output logic                  sdio_oe,
    input  logic                  sdio_i
);

    localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int PERIOD = 2 * CLKDIV;
    localparam int DIV_W  = $clog2(PERIOD);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(PERIOD - 2);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLKDIV);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_START, S_RW, S_ADDR, S_WDATA, S_WPAR,
        S_TURN, S_RDATA, S_RPAR, S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q;
    logic [DIV_W-1:0]        div_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    write_q;
    logic                    wpar_q;
    logic                    rpar_q;
    logic [ADDR_WIDTH-1:0]   addr_sh_q;
    logic [DATA_WIDTH-1:0]   wdata_sh_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_perr_q;
    logic                    bit_end;
    logic                    rsp_slot;
    logic                    accept;

    // State changes land on bit_end so every field starts on the low half of clock_target.
    assign bit_end  = (div_q == DIV_LAST);
    assign rsp_slot = (div_q == DIV_PRE);
    assign accept   = (state_q == S_IDLE) && req_valid && ready_q;

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_perr  = rsp_perr_q;

    // Bit-period divider; held at zero in reset so clock_target restarts low.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
        end else if (bit_end) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // State register; ready tracks the upcoming state so it is low during reset and the
    // cycle after a request is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    // Next-state logic: WAIT is skipped when a request lands on the last cycle of a period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)  state_d = bit_end ? S_START : S_WAIT;
            S_WAIT:  if (bit_end) state_d = S_START;
            S_START: if (bit_end) state_d = S_RW;
            S_RW:    if (bit_end) state_d = S_ADDR;
            S_ADDR:  if (bit_end && cnt_q == '0) state_d = write_q ? S_WDATA : S_TURN;
            S_WDATA: if (bit_end && cnt_q == '0) state_d = S_WPAR;
            S_WPAR:  if (bit_end) state_d = S_STOP;
            S_TURN:  if (bit_end) state_d = S_RDATA;
            S_RDATA: if (bit_end && cnt_q == '0) state_d = S_RPAR;
            S_RPAR:  if (bit_end) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read shift-in value: MSB arrives first, so older bits move up.
    always_comb begin
        rdata_d    = rdata_q << 1;
        rdata_d[0] = sdio_i;
    end

    // Frame datapath: request capture, field shifting, line sampling and completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            wpar_q      <= 1'b0;
            rpar_q      <= 1'b0;
            addr_sh_q   <= '0;
            wdata_sh_q  <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                addr_sh_q  <= req_addr;
                wdata_sh_q <= req_wdata;
                wpar_q     <= ^req_wdata;
            end
            if (bit_end) begin
                case (state_q)
                    S_RW:    cnt_q <= ADDR_LAST;
                    S_ADDR: begin
                        addr_sh_q <= addr_sh_q << 1;
                        cnt_q     <= (cnt_q == '0) ? DATA_LAST : cnt_q - CNT_W'(1);
                    end
                    S_WDATA: begin
                        wdata_sh_q <= wdata_sh_q << 1;
                        cnt_q      <= cnt_q - CNT_W'(1);
                    end
                    S_TURN:  cnt_q <= DATA_LAST;
                    S_RDATA: begin
                        rdata_q <= rdata_d;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                    S_RPAR:  rpar_q <= sdio_i;
                    default: ;
                endcase
            end
            // Registered one cycle early so the pulse coincides with the last STOP cycle.
            rsp_valid_q <= 1'b0;
            if (state_q == S_STOP && rsp_slot) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= write_q ? '0 : rdata_q;
                rsp_perr_q  <= write_q ? 1'b0 : ((^rdata_q) != rpar_q);
            end
        end
    end

    // Line drive and target clock; released fields leave the pull-up to hold the line high.
    always_comb begin
        clock_target = (div_q >= DIV_HALF);
        sdio_oe      = 1'b0;
        sdio_o       = 1'b1;
        case (state_q)
            S_START: begin sdio_oe = 1'b1; sdio_o = 1'b0;                       end
            S_RW:    begin sdio_oe = 1'b1; sdio_o = write_q;                    end
            S_ADDR:  begin sdio_oe = 1'b1; sdio_o = addr_sh_q[ADDR_WIDTH-1];    end
            S_WDATA: begin sdio_oe = 1'b1; sdio_o = wdata_sh_q[DATA_WIDTH-1];   end
            S_WPAR:  begin sdio_oe = 1'b1; sdio_o = wpar_q;                     end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rio_host_param.sv
// tb/tb_rio_host_param.sv - self-checking bench for rio_host_param (default and 4/16/1 builds)
module tb_rio_host_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    logic reset;
    logic tgt_en, tgt_val;
    bit   sel;

    logic       v1, w1, rdy1, rv1, perr1, ct1, so1, soe1, si1;
    logic [7:0] a1, wd1, rd1;
    logic        v2, w2, rdy2, rv2, perr2, ct2, so2, soe2, si2;
    logic [3:0]  a2;
    logic [15:0] wd2, rd2;

    assign si1 = soe1 ? so1 : (tgt_en ? tgt_val : 1'b1);
    assign si2 = soe2 ? so2 : (tgt_en ? tgt_val : 1'b1);

    rio_host_param dut1 (
        .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_perr(perr1),
        .clock_target(ct1), .sdio_o(so1), .sdio_oe(soe1), .sdio_i(si1)
    );

    rio_host_param #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CLKDIV(1)) dut2 (
        .clock(clock), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_write(w2),
        .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_perr(perr2),
        .clock_target(ct2), .sdio_o(so2), .sdio_oe(soe2), .sdio_i(si2)
    );

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        bit          sel;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wd;
        bit          wpar;
        logic [15:0] td;
        bit          tpar;
        logic [15:0] erd;
        bit          eperr;
        int          ecyc;
    } vec_t;

    vec_t vecs[8];

    function automatic logic cur_oe();   return sel ? soe2 : soe1;  endfunction
    function automatic logic cur_o();    return sel ? so2 : so1;    endfunction
    function automatic logic cur_ct();   return sel ? ct2 : ct1;    endfunction
    function automatic logic cur_rdy();  return sel ? rdy2 : rdy1;  endfunction
    function automatic logic cur_rv();   return sel ? rv2 : rv1;    endfunction
    function automatic logic cur_perr(); return sel ? perr2 : perr1; endfunction
    function automatic logic [15:0] cur_rdata(); return sel ? rd2 : {8'h00, rd1}; endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input bit s, input bit v, input bit wr, input logic [7:0] addr,
                             input logic [15:0] wd);
        if (s) begin v2 = v; w2 = wr; a2 = addr[3:0]; wd2 = wd; end
        else   begin v1 = v; w1 = wr; a1 = addr; wd1 = wd[7:0]; end
    endtask

    task automatic issue(input bit s, input bit wr, input logic [7:0] addr, input logic [15:0] wd,
                         output bit ok);
        sel = s;
        ok  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cur_rdy() === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        drive_req(s, ok, wr, addr, wd);
        @(negedge clock);
    endtask

    task automatic observe(input string tag, input bit s, input bit wr, input logic [7:0] addr,
                           input logic [15:0] wd, input bit wpar, input logic [15:0] td,
                           input bit tpar, input logic [15:0] erd, input bit eperr,
                           input int ecyc, input bit chk_lat,
                           output int t_start, output int t_done);
        int A, D, P, n, lat, drv_err, clk_err, rv_err;
        bit found, lastc;
        bit eoe[40];
        bit ev[40];
        bit ten[40];
        bit tv[40];
        sel = s;
        A = s ? 4 : 8;
        D = s ? 16 : 8;
        P = s ? 2 : 4;
        for (int k = 0; k < 40; k++) begin eoe[k] = 0; ev[k] = 1; ten[k] = 0; tv[k] = 1; end
        eoe[0] = 1; ev[0] = 0;
        eoe[1] = 1; ev[1] = wr;
        n = 2;
        for (int k = 0; k < A; k++) begin eoe[n] = 1; ev[n] = addr[A-1-k]; n++; end
        if (wr) begin
            for (int k = 0; k < D; k++) begin eoe[n] = 1; ev[n] = wd[D-1-k]; n++; end
            eoe[n] = 1; ev[n] = wpar; n++;
        end else begin
            n++;
            for (int k = 0; k < D; k++) begin ten[n] = 1; tv[n] = td[D-1-k]; n++; end
            ten[n] = 1; tv[n] = tpar; n++;
        end
        n++;
        t_start = cyc;
        t_done  = cyc;
        found = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (cur_oe() === 1'b1 && cur_o() === 1'b0) begin found = 1; break; end
            @(negedge clock);
            lat++;
        end
        check({tag, "_start_seen"}, found, 1);
        if (!found) return;
        if (chk_lat) check({tag, "_latency"}, (lat + 1 >= 1 && lat + 1 <= P), 1);
        t_start = cyc;
        drv_err = 0; clk_err = 0; rv_err = 0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < P; c++) begin
                if (c == 0) begin tgt_en = ten[b]; tgt_val = tv[b]; end
                if (cur_oe() !== eoe[b] || (eoe[b] && cur_o() !== ev[b])) drv_err++;
                if (cur_ct() !== (c >= P / 2)) clk_err++;
                lastc = (b == n - 1) && (c == P - 1);
                if (cur_rv() !== lastc) rv_err++;
                if (!lastc) @(negedge clock);
            end
        end
        t_done = cyc;
        tgt_en = 0;
        check({tag, "_drive"}, drv_err, 0);
        check({tag, "_clock_target"}, clk_err, 0);
        check({tag, "_rsp_timing"}, rv_err, 0);
        check({tag, "_frame_cycles"}, t_done - t_start + 1, ecyc);
        check({tag, "_rdata"}, cur_rdata(), erd);
        check({tag, "_perr"}, cur_perr(), eperr);
    endtask

    task automatic run_vector(input int i);
        vec_t v;
        bit ok;
        int ts, tdn;
        string tag;
        v = vecs[i];
        tag = $sformatf("v%0d", i);
        issue(v.sel, v.wr, v.addr, v.wd, ok);
        check({tag, "_accept"}, ok, 1);
        drive_req(v.sel, 0, v.wr, v.addr, v.wd);
        if (!ok) return;
        observe(tag, v.sel, v.wr, v.addr, v.wd, v.wpar, v.td, v.tpar, v.erd, v.eperr, v.ecyc, 1,
                ts, tdn);
        @(negedge clock);
        check({tag, "_pulse_once"}, cur_rv(), 0);
        check({tag, "_ready_after"}, cur_rdy(), 1);
        check({tag, "_rdata_hold"}, cur_rdata(), v.erd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, found, rv_seen, oe_seen;
        int ts1, td1, ts2, td2;

        vecs[0] = '{sel:0, wr:1, addr:8'h5A, wd:16'h003C, wpar:0, td:16'h0000, tpar:0, erd:16'h0000, eperr:0, ecyc:80};
        vecs[1] = '{sel:0, wr:0, addr:8'h12, wd:16'h0000, wpar:0, td:16'h0081, tpar:0, erd:16'h0081, eperr:0, ecyc:84};
        vecs[2] = '{sel:0, wr:0, addr:8'h12, wd:16'h0000, wpar:0, td:16'h0081, tpar:1, erd:16'h0081, eperr:1, ecyc:84};
        vecs[3] = '{sel:0, wr:1, addr:8'hFF, wd:16'h0001, wpar:1, td:16'h0000, tpar:0, erd:16'h0000, eperr:0, ecyc:80};
        vecs[4] = '{sel:0, wr:0, addr:8'h00, wd:16'h0000, wpar:0, td:16'h007F, tpar:1, erd:16'h007F, eperr:0, ecyc:84};
        vecs[5] = '{sel:1, wr:0, addr:8'h0A, wd:16'h0000, wpar:0, td:16'hBEEF, tpar:1, erd:16'hBEEF, eperr:0, ecyc:50};
        vecs[6] = '{sel:1, wr:1, addr:8'h03, wd:16'h8001, wpar:0, td:16'h0000, tpar:0, erd:16'h0000, eperr:0, ecyc:48};
        vecs[7] = '{sel:1, wr:0, addr:8'h05, wd:16'h0000, wpar:0, td:16'h0001, tpar:0, erd:16'h0001, eperr:1, ecyc:50};

        reset = 1; tgt_en = 0; tgt_val = 1; sel = 0;
        drive_req(0, 0, 0, 8'h00, 16'h0000);
        drive_req(1, 0, 0, 8'h00, 16'h0000);
        repeat (3) @(negedge clock);
        check("reset_clock_target", ct1, 0);
        check("reset_sdio_oe", soe1, 0);
        check("reset_sdio_o", so1, 1);
        check("reset_req_ready", rdy1, 0);
        check("reset_rsp_valid", rv1, 0);
        check("reset_rsp_rdata", rd1, 0);
        check("reset_rsp_perr", perr1, 0);
        check("reset_dut2_ready", rdy2, 0);
        reset = 0;
        @(negedge clock);
        check("release_ready", rdy1, 1);
        check("release_dut2_ready", rdy2, 1);

        for (int i = 0; i < 8; i++) run_vector(i);

        // Write then read with req_valid held throughout.
        issue(0, 1, 8'hC3, 16'h00A5, ok);
        check("b2b_accept", ok, 1);
        drive_req(0, 1, 0, 8'h3E, 16'h0000);
        observe("b2b_wr", 0, 1, 8'hC3, 16'h00A5, 0, 16'h0000, 0, 16'h0000, 0, 80, 1, ts1, td1);
        @(negedge clock);
        check("b2b_ready", rdy1, 1);
        @(negedge clock);
        drive_req(0, 0, 0, 8'h3E, 16'h0000);
        observe("b2b_rd", 0, 0, 8'h3E, 16'h0000, 0, 16'h0055, 0, 16'h0055, 0, 84, 0, ts2, td2);
        check("b2b_gap", ts2 - td1, 5);
        @(negedge clock);

        // Reset in the middle of ADDR.
        issue(0, 1, 8'h96, 16'h000F, ok);
        check("rst_accept", ok, 1);
        drive_req(0, 0, 1, 8'h96, 16'h000F);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (soe1 === 1'b1 && so1 === 1'b0) begin found = 1; break; end
            @(negedge clock);
        end
        check("rst_start_seen", found, 1);
        repeat (17) @(negedge clock);
        check("rst_mid_addr_oe", soe1, 1);
        reset = 1;
        @(negedge clock);
        check("rst_sdio_oe", soe1, 0);
        check("rst_clock_target", ct1, 0);
        check("rst_rsp_valid", rv1, 0);
        check("rst_req_ready", rdy1, 0);
        reset = 0;
        rv_seen = 0; oe_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rv1 !== 1'b0) rv_seen = 1;
            if (soe1 !== 1'b0) oe_seen = 1;
        end
        check("rst_no_rsp", rv_seen, 0);
        check("rst_line_idle", oe_seen, 0);
        check("rst_ready_back", rdy1, 1);
        run_vector(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
